ttc_cfg_sequencer18: RTL and testbench

Configuration sequencer and write-port arbiter for one triple-timer-counter channel. On a single start pulse it programs a complete timer setup into the channel's register selects: stop the counter, clear pending interrupts, write clock control, interval, match 1-3 and interrupt enable, then restart. It also shares the channel's write port with the APB host decode path, stalling host writes while a sequence is in progress. It sits between the APB slave decode and the timer-counter instance, driving that instance's `pwdata18`, `*_reg_sel18` and `clear_interrupt18` inputs.

---
 rtl/ttc_cfg_sequencer18.sv | 258 +++++++++++++++++++++++++
 tb/tb_ttc_cfg_sequencer18.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_cfg_sequencer18.sv
// ttc_cfg_sequencer18
// Configuration sequencer and write-port arbiter for one timer-counter
// channel. A start pulse snapshots the cfg_* inputs and replays them as a
// fixed series of register writes: stop, clear interrupts, clock control,
// interval, match 1-3, interrupt enable, restart. Between sequences the
// channel write port is handed to the APB host path.
//
// Host handshake: apb_wr_req18 is the valid; apb_ready18 is the ready.
// A host write completes in the cycle where both are 1. ready may only be 1
// when the port is free (IDLE, or the done cycle, with no start being
// accepted). The host must hold req, sel and wdata stable until it sees
// ready; the select and data are forwarded combinationally in that cycle.

module ttc_cfg_sequencer18 #(
  parameter int WR_GAP = 0
) (
  input  logic        pclk18,
  input  logic        n_p_reset18,
  input  logic        start18,
  input  logic [5:0]  cfg_mask18,
  input  logic [6:0]  cfg_clk_ctrl18,
  input  logic [6:0]  cfg_cntr_ctrl18,
  input  logic [15:0] cfg_interval18,
  input  logic [15:0] cfg_match_1_18,
  input  logic [15:0] cfg_match_2_18,
  input  logic [15:0] cfg_match_3_18,
  input  logic [5:0]  cfg_intr_en18,
  input  logic        apb_wr_req18,
  input  logic [6:0]  apb_sel18,
  input  logic [15:0] apb_wdata18,
  output logic        apb_ready18,
  output logic [15:0] pwdata18,
  output logic        clk_ctrl_reg_sel18,
  output logic        cntr_ctrl_reg_sel18,
  output logic        interval_reg_sel18,
  output logic        match_1_reg_sel18,
  output logic        match_2_reg_sel18,
  output logic        match_3_reg_sel18,
  output logic        intr_en_reg_sel18,
  output logic        clear_interrupt18,
  output logic        busy18,
  output logic        done18,
  output logic [3:0]  state_dbg18
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_STOP = 4'd1,
    S_CLR  = 4'd2,
    S_CLK  = 4'd3,
    S_INTV = 4'd4,
    S_M1   = 4'd5,
    S_M2   = 4'd6,
    S_M3   = 4'd7,
    S_IEN  = 4'd8,
    S_GO   = 4'd9,
    S_GAP  = 4'd10
  } state_t;

  // GAP counts down from WR_GAP-1 to 0, so it spans exactly WR_GAP cycles.
  localparam int          GAP_N    = (WR_GAP > 0) ? (WR_GAP - 1) : 0;
  localparam logic [2:0]  GAP_LAST = GAP_N[2:0];

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [2:0]  gap_q, gap_d;
  logic        done_q, done_d;

  logic [5:0]  sh_mask;
  logic [6:0]  sh_clk;
  logic [6:0]  sh_cntr;
  logic [15:0] sh_intv;
  logic [15:0] sh_m1;
  logic [15:0] sh_m2;
  logic [15:0] sh_m3;
  logic [5:0]  sh_ien;

  logic        accept_start;
  logic        host_en;
  logic        sel_onehot;
  logic        host_fwd;
  logic [6:0]  seq_sel;
  logic        seq_clr;
  logic [15:0] seq_data;
  logic [15:0] go_word;

  // The done cycle leaves state at IDLE but still counts as busy, so a start
  // arriving then is dropped; the next start is taken one cycle later.
  assign accept_start = (state_q == S_IDLE) && !done_q && start18;

  // The restart word: shadow counter control with restart set, disable clear.
  assign go_word = {9'b0, sh_cntr[6:5], 1'b1, sh_cntr[3:1], 1'b0};

  // First enabled data write strictly after cur; falls through to GO.
  // Mask bit i maps to state i+3 (CLK..IEN). Scanning high to low leaves the
  // lowest qualifying state in n.
  function automatic state_t next_write(input state_t cur, input logic [5:0] m);
    state_t n;
    n = S_GO;
    for (int i = 5; i >= 0; i--) begin
      if (m[i] && ((i + 3) > int'(cur))) begin
        n = state_t'(4'(i + 3));
      end
    end
    return n;
  endfunction

  // State, gap counter, done flag and shadow registers.
  always_ff @(posedge pclk18 or negedge n_p_reset18) begin
    if (!n_p_reset18) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      gap_q   <= 3'd0;
      done_q  <= 1'b0;
      sh_mask <= 6'd0;
      sh_clk  <= 7'd0;
      sh_cntr <= 7'd0;
      sh_intv <= 16'd0;
      sh_m1   <= 16'd0;
      sh_m2   <= 16'd0;
      sh_m3   <= 16'd0;
      sh_ien  <= 6'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      if (accept_start) begin
        sh_mask <= cfg_mask18;
        sh_clk  <= cfg_clk_ctrl18;
        sh_cntr <= cfg_cntr_ctrl18;
        sh_intv <= cfg_interval18;
        sh_m1   <= cfg_match_1_18;
        sh_m2   <= cfg_match_2_18;
        sh_m3   <= cfg_match_3_18;
        sh_ien  <= cfg_intr_en18;
      end
    end
  end

  // Next state: walk the write list, detouring through GAP after each strobe.
  always_comb begin
    state_t target;
    logic   strobe;
    state_d = state_q;
    ret_d   = ret_q;
    gap_d   = gap_q;
    target  = S_IDLE;
    strobe  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        target = S_CLR;
        strobe = 1'b1;
      end
      S_CLR, S_CLK, S_INTV, S_M1, S_M2, S_M3, S_IEN: begin
        target = next_write(state_q, sh_mask);
        strobe = 1'b1;
      end
      S_GO: begin
        target = S_IDLE;
        strobe = 1'b1;
      end
      S_GAP: begin
        if (gap_q == 3'd0) begin
          state_d = ret_q;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (strobe) begin
      if (WR_GAP == 0) begin
        state_d = target;
      end else begin
        state_d = S_GAP;
        ret_d   = target;
        gap_d   = GAP_LAST;
      end
    end
    // The only way back to IDLE from a non-IDLE state is sequence completion.
    done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
  end

  // Outputs: sequencer strobes decoded from state, host path merged on top.
  always_comb begin
    seq_sel  = 7'd0;
    seq_clr  = 1'b0;
    seq_data = 16'd0;
    case (state_q)
      S_STOP: begin
        seq_sel[1] = 1'b1;
        seq_data   = 16'h0001;
      end
      S_CLR: begin
        seq_clr = 1'b1;
      end
      S_CLK: begin
        seq_sel[0] = 1'b1;
        seq_data   = {9'b0, sh_clk};
      end
      S_INTV: begin
        seq_sel[2] = 1'b1;
        seq_data   = sh_intv;
      end
      S_M1: begin
        seq_sel[3] = 1'b1;
        seq_data   = sh_m1;
      end
      S_M2: begin
        seq_sel[4] = 1'b1;
        seq_data   = sh_m2;
      end
      S_M3: begin
        seq_sel[5] = 1'b1;
        seq_data   = sh_m3;
      end
      S_IEN: begin
        seq_sel[6] = 1'b1;
        seq_data   = {10'b0, sh_ien};
      end
      S_GO: begin
        seq_sel[1] = 1'b1;
        seq_data   = go_word;
      end
      default: begin
        seq_sel  = 7'd0;
        seq_clr  = 1'b0;
        seq_data = 16'd0;
      end
    endcase

    // Host owns the port only when the sequencer is idle and not starting;
    // reset blocks it so every output is 0 while reset is held.
    host_en     = n_p_reset18 && (state_q == S_IDLE) && !accept_start;
    apb_ready18 = host_en && apb_wr_req18;
    sel_onehot  = (apb_sel18 != 7'd0) && ((apb_sel18 & (apb_sel18 - 7'd1)) == 7'd0);
    // A bad select is still consumed (ready=1) but nothing is strobed.
    host_fwd    = apb_ready18 && sel_onehot;

    {intr_en_reg_sel18, match_3_reg_sel18, match_2_reg_sel18, match_1_reg_sel18,
     interval_reg_sel18, cntr_ctrl_reg_sel18, clk_ctrl_reg_sel18} =
      seq_sel | (host_fwd ? apb_sel18 : 7'd0);
    pwdata18          = host_fwd ? apb_wdata18 : seq_data;
    clear_interrupt18 = seq_clr;
    busy18            = (state_q != S_IDLE) || done_q;
    done18            = done_q;
    state_dbg18       = state_q;
  end

endmodule

// File: tb/tb_ttc_cfg_sequencer18.sv
// Directed bench for ttc_cfg_sequencer18. Two instances share the cfg and host
// inputs: dut0 with WR_GAP=0 and dut2 with WR_GAP=2, each with its own start.
// Inputs change on the falling edge; outputs are checked #1 later.

module tb_ttc_cfg_sequencer18;

  logic        clk;
  logic        rst_n;
  logic        start0, start2;
  logic [5:0]  cfg_mask;
  logic [6:0]  cfg_clk, cfg_cntr;
  logic [15:0] cfg_intv, cfg_m1, cfg_m2, cfg_m3;
  logic [5:0]  cfg_ien;
  logic        req;
  logic [6:0]  sel;
  logic [15:0] wdata;

  logic        ready0, ready2;
  logic [15:0] pwd0, pwd2;
  logic        clk_s0, cntr_s0, intv_s0, m1_s0, m2_s0, m3_s0, ien_s0, clr0, busy0, done0;
  logic        clk_s2, cntr_s2, intv_s2, m1_s2, m2_s2, m3_s2, ien_s2, clr2, busy2, done2;
  logic [3:0]  st0, st2;

  int n_cmp;
  int n_err;
  logic [24:0] exp_q[$];

  ttc_cfg_sequencer18 #(.WR_GAP(0)) dut0 (
    .pclk18(clk), .n_p_reset18(rst_n), .start18(start0),
    .cfg_mask18(cfg_mask), .cfg_clk_ctrl18(cfg_clk), .cfg_cntr_ctrl18(cfg_cntr),
    .cfg_interval18(cfg_intv), .cfg_match_1_18(cfg_m1), .cfg_match_2_18(cfg_m2),
    .cfg_match_3_18(cfg_m3), .cfg_intr_en18(cfg_ien),
    .apb_wr_req18(req), .apb_sel18(sel), .apb_wdata18(wdata), .apb_ready18(ready0),
    .pwdata18(pwd0), .clk_ctrl_reg_sel18(clk_s0), .cntr_ctrl_reg_sel18(cntr_s0),
    .interval_reg_sel18(intv_s0), .match_1_reg_sel18(m1_s0), .match_2_reg_sel18(m2_s0),
    .match_3_reg_sel18(m3_s0), .intr_en_reg_sel18(ien_s0), .clear_interrupt18(clr0),
    .busy18(busy0), .done18(done0), .state_dbg18(st0)
  );

  ttc_cfg_sequencer18 #(.WR_GAP(2)) dut2 (
    .pclk18(clk), .n_p_reset18(rst_n), .start18(start2),
    .cfg_mask18(cfg_mask), .cfg_clk_ctrl18(cfg_clk), .cfg_cntr_ctrl18(cfg_cntr),
    .cfg_interval18(cfg_intv), .cfg_match_1_18(cfg_m1), .cfg_match_2_18(cfg_m2),
    .cfg_match_3_18(cfg_m3), .cfg_intr_en18(cfg_ien),
    .apb_wr_req18(req), .apb_sel18(sel), .apb_wdata18(wdata), .apb_ready18(ready2),
    .pwdata18(pwd2), .clk_ctrl_reg_sel18(clk_s2), .cntr_ctrl_reg_sel18(cntr_s2),
    .interval_reg_sel18(intv_s2), .match_1_reg_sel18(m1_s2), .match_2_reg_sel18(m2_s2),
    .match_3_reg_sel18(m3_s2), .intr_en_reg_sel18(ien_s2), .clear_interrupt18(clr2),
    .busy18(busy2), .done18(done2), .state_dbg18(st2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of one cycle: {done, clear, sel[6:0], pwdata}.
  function automatic logic [24:0] mk(input logic d, input logic c, input logic [6:0] s,
                                     input logic [15:0] w);
    return {d, c, s, w};
  endfunction

  function automatic logic [24:0] obs0();
    return {done0, clr0, ien_s0, m3_s0, m2_s0, m1_s0, intv_s0, cntr_s0, clk_s0, pwd0};
  endfunction

  function automatic logic [24:0] obs2();
    return {done2, clr2, ien_s2, m3_s2, m2_s2, m1_s2, intv_s2, cntr_s2, clk_s2, pwd2};
  endfunction

  task automatic set_full_cfg();
    cfg_mask = 6'h3F;
    cfg_clk  = 7'h05;
    cfg_cntr = 7'h02;
    cfg_intv = 16'h1234;
    cfg_m1   = 16'h0010;
    cfg_m2   = 16'h0020;
    cfg_m3   = 16'h0030;
    cfg_ien  = 6'h3F;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start0 = 1'b0; start2 = 1'b0;
    req = 1'b0; sel = 7'd0; wdata = 16'd0;
    set_full_cfg();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (obs0() !== 25'd0 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h busy %b, want 0 busy 0", obs0(), busy0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (st0 !== 4'd0 || st2 !== 4'd0 || ready0 !== 1'b0 || obs2() !== 25'd0) begin
      n_err++;
      $display("FAIL reset_release: st0 %0d st2 %0d ready0 %b obs2 %h, want 0 0 0 0",
               st0, st2, ready0, obs2());
    end
  endtask

  task automatic test_full_config();
    logic [24:0] e;
    set_full_cfg();
    exp_q = {};
    exp_q.push_back(mk(0, 0, 7'h02, 16'h0001));
    exp_q.push_back(mk(0, 1, 7'h00, 16'h0000));
    exp_q.push_back(mk(0, 0, 7'h01, 16'h0005));
    exp_q.push_back(mk(0, 0, 7'h04, 16'h1234));
    exp_q.push_back(mk(0, 0, 7'h08, 16'h0010));
    exp_q.push_back(mk(0, 0, 7'h10, 16'h0020));
    exp_q.push_back(mk(0, 0, 7'h20, 16'h0030));
    exp_q.push_back(mk(0, 0, 7'h40, 16'h003F));
    exp_q.push_back(mk(0, 0, 7'h02, 16'h0012));
    exp_q.push_back(mk(1, 0, 7'h00, 16'h0000));
    exp_q.push_back(mk(0, 0, 7'h00, 16'h0000));
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs0() !== e) begin
        n_err++;
        $display("FAIL full_cycle%0d: got %h want %h", c, obs0(), e);
      end
      if (c == 1 || c == 10 || c == 11) begin
        n_cmp++;
        if (busy0 !== (c != 11)) begin
          n_err++;
          $display("FAIL full_busy_cycle%0d: got %b want %b", c, busy0, (c != 11));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_masked_gap();
    logic [24:0] e;
    cfg_mask = 6'b000010;
    cfg_cntr = 7'h02;
    cfg_intv = 16'hA5A5;
    exp_q = {};
    for (int c = 1; c <= 14; c++) begin
      case (c)
        1:       exp_q.push_back(mk(0, 0, 7'h02, 16'h0001));
        4:       exp_q.push_back(mk(0, 1, 7'h00, 16'h0000));
        7:       exp_q.push_back(mk(0, 0, 7'h04, 16'hA5A5));
        10:      exp_q.push_back(mk(0, 0, 7'h02, 16'h0012));
        13:      exp_q.push_back(mk(1, 0, 7'h00, 16'h0000));
        default: exp_q.push_back(mk(0, 0, 7'h00, 16'h0000));
      endcase
    end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs2() !== e) begin
        n_err++;
        $display("FAIL gap_cycle%0d: got %h want %h", c, obs2(), e);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_err++;
      $display("FAIL gap_idle_busy: got %b want 0", busy2);
    end
  endtask

  task automatic test_host_arbitration();
    cfg_mask = 6'd0;
    cfg_cntr = 7'h02;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    req = 1'b1; sel = 7'h04; wdata = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_cmp++;
      if (ready0 !== 1'b0 || pwd0 === 16'hBEEF) begin
        n_err++;
        $display("FAIL stall_cycle%0d: ready %b pwdata %h, want ready 0 no host data",
                 c, ready0, pwd0);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (done0 !== 1'b1 || ready0 !== 1'b1 || intv_s0 !== 1'b1 || pwd0 !== 16'hBEEF) begin
      n_err++;
      $display("FAIL done_forward: done %b ready %b intv %b pwdata %h, want 1 1 1 beef",
               done0, ready0, intv_s0, pwd0);
    end
    @(negedge clk);
    req = 1'b0;
    // start and host request in the same idle cycle: start wins
    start0 = 1'b1; req = 1'b1; sel = 7'h04; wdata = 16'h5555;
    #1;
    n_cmp++;
    if (ready0 !== 1'b0 || intv_s0 !== 1'b0 || pwd0 !== 16'h0000) begin
      n_err++;
      $display("FAIL start_wins: ready %b intv %b pwdata %h, want 0 0 0000",
               ready0, intv_s0, pwd0);
    end
    @(negedge clk);
    start0 = 1'b0;
    #1;
    n_cmp++;
    if (busy0 !== 1'b1 || cntr_s0 !== 1'b1 || pwd0 !== 16'h0001 || ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_stop: busy %b cntr %b pwdata %h ready %b, want 1 1 0001 0",
               busy0, cntr_s0, pwd0, ready0);
    end
    req = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_shadow_and_busy_start();
    int dones;
    dones = 0;
    cfg_mask = 6'b000010;
    cfg_intv = 16'h1111;
    start0 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      start0 = (c == 2);
      if (c == 1) cfg_intv = 16'h2222;
      #1;
      if (done0 === 1'b1) dones++;
      if (c == 3) begin
        n_cmp++;
        if (intv_s0 !== 1'b1 || pwd0 !== 16'h1111) begin
          n_err++;
          $display("FAIL shadow_intv: sel %b pwdata %h, want 1 1111", intv_s0, pwd0);
        end
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL single_done: got %0d pulses want 1", dones);
    end
  endtask

  task automatic test_reset_mid_sequence();
    set_full_cfg();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (m2_s0 !== 1'b1 || pwd0 !== 16'h0020) begin
      n_err++;
      $display("FAIL at_m2: sel %b pwdata %h, want 1 0020", m2_s0, pwd0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs0() !== 25'd0 || busy0 !== 1'b0 || st0 !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h busy %b state %0d, want 0 0 0", obs0(), busy0, st0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 1'b1; sel = 7'h04; wdata = 16'h1357;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1 || intv_s0 !== 1'b1 || pwd0 !== 16'h1357 || busy0 !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_host: ready %b intv %b pwdata %h busy %b, want 1 1 1357 0",
               ready0, intv_s0, pwd0, busy0);
    end
    req = 1'b0;
    #1;
    n_cmp++;
    if (ready0 !== 1'b0 || obs0() !== 25'd0) begin
      n_err++;
      $display("FAIL post_reset_idle: ready %b got %h, want 0 0", ready0, obs0());
    end
    @(negedge clk);
  endtask

  task automatic test_bad_select();
    req = 1'b1; sel = 7'h00; wdata = 16'hCAFE;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1 || obs0()[22:16] !== 7'd0) begin
      n_err++;
      $display("FAIL bad_sel_zero: ready %b sel %h, want 1 00", ready0, obs0()[22:16]);
    end
    sel = 7'h03;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1 || obs0()[22:16] !== 7'd0) begin
      n_err++;
      $display("FAIL bad_sel_multi: ready %b sel %h, want 1 00", ready0, obs0()[22:16]);
    end
    req = 1'b0; sel = 7'd0;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_config();
    test_masked_gap();
    test_host_arbitration();
    test_shadow_and_busy_start();
    test_reset_mid_sequence();
    test_bad_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
